ram16k_arbiter: RTL and testbench

RAM16K_ARBITER -- requirements
Module: ram16k_arbiter

---
 rtl/ram16k_arbiter_pkg.sv | 23 ++
 rtl/ram16k.sv | 26 ++
 rtl/ram16k_arbiter.sv | 135 +++++++++++++
 tb/tb_ram16k_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram16k_arbiter_pkg.sv
// Shared sizes, FSM encoding and round-robin helper for the RAM16K arbiter.
package ram16k_arbiter_pkg;

   localparam int RAM_ADDR_W = 14;
   localparam int RAM_DATA_W = 16;
   localparam int RAM_DEPTH  = 16384;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } arb_state_t;

   // Returns 1 when requester 1 should win. With both eligible the requester
   // that was not served last wins; otherwise the lone eligible one wins.
   function automatic logic rr_pick(input logic elig0, input logic elig1,
                                    input logic last1);
      if (elig0 && elig1) begin
         return ~last1;
      end
      return elig1;
   endfunction

endpackage

// File: rtl/ram16k.sv
// 16K x 16 word RAM: combinational read of the addressed word, write on the
// rising clock edge when load is high. Contents are never reset.
module ram16k #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16384
) (
   input  logic              clk,
   input  logic [DATA_W-1:0] in,
   input  logic [ADDR_W-1:0] address,
   input  logic              load,
   output logic [DATA_W-1:0] out
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   assign out = r_mem[address];

   // Store the input word at the addressed location when load is asserted.
   always_ff @(posedge clk) begin
      if (load) begin
         r_mem[address] <= in;
      end
   end

endmodule

// File: rtl/ram16k_arbiter.sv
// Two-port round-robin arbiter in front of a single ram16k, with a
// full-memory clear sweep that stalls both requesters while it runs.
module ram16k_arbiter
   import ram16k_arbiter_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W,
   parameter int DEPTH  = RAM_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   input  logic              clear_start,
   output logic              clear_busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   arb_state_t        r_state;
   logic              r_last1;     // 1 when requester 1 was served last
   logic              r_ack0;
   logic              r_ack1;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_busy;

   logic              w_elig0;
   logic              w_elig1;
   logic              w_grant;
   logic              w_win1;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [DATA_W-1:0] w_ram_in;
   logic              w_ram_load;
   logic [DATA_W-1:0] w_ram_out;

   // A requester acked this cycle is not eligible, so a held request
   // cannot be granted twice back to back.
   assign w_elig0 = req0 & ~r_ack0;
   assign w_elig1 = req1 & ~r_ack1;
   assign w_win1  = rr_pick(w_elig0, w_elig1, r_last1);
   assign w_grant = (r_state == ST_IDLE) & ~clear_start & (w_elig0 | w_elig1);

   // RAM port mux: the clear sweep owns the RAM, otherwise the winner does;
   // load is forced low while reset is asserted.
   always_comb begin
      w_ram_addr = w_win1 ? addr1  : addr0;
      w_ram_in   = w_win1 ? wdata1 : wdata0;
      w_ram_load = w_grant & (w_win1 ? we1 : we0);
      if (r_state == ST_CLEAR) begin
         w_ram_addr = r_cnt;
         w_ram_in   = '0;
         w_ram_load = 1'b1;
      end
      if (!rst_n) begin
         w_ram_load = 1'b0;
      end
   end

   ram16k #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .in      (w_ram_in),
      .address (w_ram_addr),
      .load    (w_ram_load),
      .out     (w_ram_out)
   );

   // Arbitration / clear FSM with registered acks, read data and busy flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_last1  <= 1'b1;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_ack0 <= w_grant & ~w_win1;
         r_ack1 <= w_grant &  w_win1;
         case (r_state)
            ST_IDLE: begin
               if (clear_start) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end else if (w_grant) begin
                  r_last1 <= w_win1;
                  if (!w_win1 && !we0) begin
                     r_rdata0 <= w_ram_out;
                  end
                  if (w_win1 && !we1) begin
                     r_rdata1 <= w_ram_out;
                  end
               end
            end
            ST_CLEAR: begin
               if (r_cnt == LAST_ADDR) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack0       = r_ack0;
   assign ack1       = r_ack1;
   assign rdata0     = r_rdata0;
   assign rdata1     = r_rdata1;
   assign clear_busy = r_busy;

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Scoreboard bench for ram16k_arbiter: stimulus queues expected acks in
// order, a negedge monitor pops and compares whenever an ack appears.
module tb_ram16k_arbiter;
   import ram16k_arbiter_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [RAM_ADDR_W-1:0] addr0 = '0, addr1 = '0;
   logic [RAM_DATA_W-1:0] wdata0 = '0, wdata1 = '0;
   logic                  ack0, ack1, clear_busy;
   logic [RAM_DATA_W-1:0] rdata0, rdata1;
   logic                  clear_start = 1'b0;

   int checks = 0;
   int errors = 0;
   int n_ack0 = 0;
   int n_ack1 = 0;

   typedef struct {
      int                    id;
      logic [RAM_DATA_W-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   ram16k_arbiter #(
      .ADDR_W (RAM_ADDR_W),
      .DATA_W (RAM_DATA_W),
      .DEPTH  (RAM_DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0        (req0),
      .req1        (req1),
      .we0         (we0),
      .we1         (we1),
      .addr0       (addr0),
      .addr1       (addr1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .ack0        (ack0),
      .ack1        (ack1),
      .rdata0      (rdata0),
      .rdata1      (rdata1),
      .clear_start (clear_start),
      .clear_busy  (clear_busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Monitor: every ack is matched against the next queued expectation.
   always @(negedge clk) begin
      if (ack0 === 1'b1 && ack1 === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL both_acks actual=11 required=at most one");
      end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
         if (ack0 === 1'b1) n_ack0++;
         if (ack1 === 1'b1) n_ack1++;
         if (clear_busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL ack_during_clear actual=ack required=no ack");
         end
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack actual=ack%0d required=none", ack1 ? 1 : 0);
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.id != (ack1 ? 1 : 0) ||
                mon_e.data !== (ack1 ? rdata1 : rdata0)) begin
               errors++;
               $display("FAIL ack_data actual=ack%0d/%0h required=ack%0d/%0h",
                        ack1 ? 1 : 0, ack1 ? rdata1 : rdata0, mon_e.id, mon_e.data);
            end
         end
      end
   end

   // One transaction; called and returns at a negedge with the ack gone.
   task automatic xact(input int id, input logic we,
                       input logic [RAM_ADDR_W-1:0] a, input logic [RAM_DATA_W-1:0] d,
                       input logic [RAM_DATA_W-1:0] exp_rd, input bit push,
                       input bit chk_lat, input int bound);
      int  n;
      bit  got;
      if (push) sb_q.push_back('{id, exp_rd});
      if (id == 0) begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end
      n = 0;
      got = 1'b0;
      while (!got && n < bound) begin
         @(negedge clk);
         n++;
         got = (id == 0) ? (ack0 === 1'b1) : (ack1 === 1'b1);
      end
      if (id == 0) req0 = 1'b0; else req1 = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout actual=no ack%0d required=ack within %0d", id, bound);
      end else if (chk_lat) begin
         chk("ack_latency", n, 1);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int busy_n;
      int a0, a1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_busy", clear_busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write then read back through requester 0
      xact(0, 1'b1, 14'd5, 16'hBEEF, 16'h0000, 1, 1, 10);
      xact(0, 1'b0, 14'd5, 16'h0000, 16'hBEEF, 1, 1, 10);

      // Sustained dual reads alternate starting with requester 0
      xact(0, 1'b1, 14'd1, 16'h0A01, 16'hBEEF, 1, 1, 10);
      xact(1, 1'b1, 14'd2, 16'h0B02, 16'h0000, 1, 1, 10);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back('{0, 16'h0A01});
         sb_q.push_back('{1, 16'h0B02});
      end
      a0 = n_ack0;
      a1 = n_ack1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 14'd1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 14'd2;
      repeat (8) @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      chk("dual_ack0_count", n_ack0 - a0, 4);
      chk("dual_ack1_count", n_ack1 - a1, 4);

      // Simultaneous writes to one address: 0 first, then 1 wins last
      do_reset();
      sb_q.push_back('{0, 16'h0000});
      sb_q.push_back('{1, 16'h0000});
      fork
         xact(0, 1'b1, 14'd9, 16'h1111, 16'h0000, 0, 0, 10);
         xact(1, 1'b1, 14'd9, 16'h2222, 16'h0000, 0, 0, 10);
      join
      xact(0, 1'b0, 14'd9, 16'h0000, 16'h2222, 1, 1, 10);

      // Full clear with requester 1 pending
      xact(0, 1'b1, 14'd0,     16'h1234, 16'h2222, 1, 1, 10);
      xact(0, 1'b1, 14'd100,   16'h5678, 16'h2222, 1, 1, 10);
      xact(0, 1'b1, 14'd16383, 16'h7777, 16'h2222, 1, 1, 10);
      xact(0, 1'b0, 14'd100,   16'h0000, 16'h5678, 1, 1, 10);
      xact(1, 1'b0, 14'd16383, 16'h0000, 16'h7777, 1, 1, 10);
      fork
         xact(1, 1'b0, 14'd16383, 16'h0000, 16'h0000, 1, 0, 20000);
         begin
            clear_start = 1'b1;
            @(negedge clk);
            clear_start = 1'b0;
            chk("clear_busy_rise", clear_busy, 1);
            busy_n = 1;
            while (clear_busy === 1'b1 && busy_n < 20000) begin
               @(negedge clk);
               if (clear_busy === 1'b1) busy_n++;
            end
            chk("clear_busy_cycles", busy_n, RAM_DEPTH);
         end
      join
      xact(0, 1'b0, 14'd0,     16'h0000, 16'h0000, 1, 1, 10);
      xact(0, 1'b0, 14'd100,   16'h0000, 16'h0000, 1, 1, 10);
      xact(0, 1'b0, 14'd16383, 16'h0000, 16'h0000, 1, 1, 10);

      // Reset in the middle of a sweep
      xact(0, 1'b1, 14'd49,    16'h4949, 16'h0000, 1, 1, 10);
      xact(0, 1'b1, 14'd50,    16'h5050, 16'h0000, 1, 1, 10);
      xact(0, 1'b1, 14'd16383, 16'h3FFF, 16'h0000, 1, 1, 10);
      xact(0, 1'b0, 14'd16383, 16'h0000, 16'h3FFF, 1, 1, 10);
      xact(1, 1'b0, 14'd50,    16'h0000, 16'h5050, 1, 1, 10);
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", clear_busy, 0);
      chk("abort_ack0", ack0, 0);
      chk("abort_ack1", ack1, 0);
      chk("abort_rdata0", rdata0, 0);
      chk("abort_rdata1", rdata1, 0);
      rst_n = 1'b1;
      @(negedge clk);
      xact(0, 1'b0, 14'd49,    16'h0000, 16'h0000, 1, 1, 10);
      xact(0, 1'b0, 14'd50,    16'h0000, 16'h5050, 1, 1, 10);
      xact(0, 1'b0, 14'd16383, 16'h0000, 16'h3FFF, 1, 1, 10);

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
